// File: rtl/mul_pkg.sv
// Shared definitions for the multi-cycle multiply sequencer.
//   - state_t   : sequencer states
//   - ALU_ADD   : ALU opcode the stage forces while the sequencer owns the ALU
//   - DEF_WIDTH : default operand width
package mul_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam logic [2:0]  ALU_ADD   = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mul_sign_fix.sv
// Conditional two's-complement negate. It is used on the way in, to take
// operand magnitudes, and on the way out, to apply the sign to the
// 2W-bit product.
//   i_neg : 1 = negate i_val
//   i_val : input value (W bits)
//   o_val : i_neg ? -i_val : i_val
module mul_sign_fix
  import mul_pkg::*;
#(
  parameter int unsigned W = DEF_WIDTH
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mul_sequencer.sv
// Shift-add multiply sequencer for the execute stage. It borrows the shared
// ALU as its adder for WIDTH iterations, owns the HI/LO result registers and
// asks the hazard unit to stall while an operation is in flight.
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_start, i_sgn       : multiply request, signed select
//   i_srca, i_srcb       : operands, sampled with i_start in IDLE
//   i_hilo_rd            : E-stage instruction reads HI/LO
//   i_alu_sum            : ALU result while o_alu_sel = 1
//   o_alu_sel            : sequencer owns the ALU (op forced to add)
//   o_alu_a, o_alu_b     : ALU operands, 0 outside ITER
//   o_busy, o_done       : in flight / one-cycle result-written pulse
//   o_stall_req          : stall request to the hazard unit
//   o_hi, o_lo           : result registers
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sgn,
  input  logic [WIDTH-1:0] i_srca,
  input  logic [WIDTH-1:0] i_srcb,
  input  logic             i_hilo_rd,
  input  logic [WIDTH-1:0] i_alu_sum,
  output logic             o_alu_sel,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_stall_req,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_p_hi;
  logic [WIDTH-1:0]   r_p_lo;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_busy;
  logic               r_alu_sel;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_res;
  logic               w_carry;

  // Operand magnitudes; only signed requests with a negative operand flip.
  mul_sign_fix #(.W(WIDTH)) u_pre_a (
    .i_neg (i_sgn & i_srca[WIDTH-1]),
    .i_val (i_srca),
    .o_val (w_mag_a)
  );

  mul_sign_fix #(.W(WIDTH)) u_pre_b (
    .i_neg (i_sgn & i_srcb[WIDTH-1]),
    .i_val (i_srcb),
    .o_val (w_mag_b)
  );

  // Apply the result sign to the full 2W-bit product.
  mul_sign_fix #(.W(2*WIDTH)) u_post (
    .i_neg (r_neg),
    .i_val ({r_p_hi, r_p_lo}),
    .o_val (w_res)
  );

  // Carry out of P_hi + addend: the sum wrapped below P_hi.
  assign w_carry = (i_alu_sum < r_p_hi);

  // Main sequencer: capture, iterate, sign-fix and write HI/LO.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_m       <= '0;
      r_p_hi    <= '0;
      r_p_lo    <= '0;
      r_neg     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_alu_sel <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_m       <= w_mag_a;
            r_p_lo    <= w_mag_b;
            r_p_hi    <= '0;
            r_neg     <= i_sgn & (i_srca[WIDTH-1] ^ i_srcb[WIDTH-1]);
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_alu_sel <= 1'b1;
            r_state   <= ITER;
          end
        end
        ITER: begin
          // {carry, sum, P_lo} shifted right by one into {P_hi, P_lo}.
          r_p_hi <= {w_carry, i_alu_sum[WIDTH-1:1]};
          r_p_lo <= {i_alu_sum[0], r_p_lo[WIDTH-1:1]};
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_alu_sel <= 1'b0;
            r_state   <= FIX;
          end
        end
        FIX: begin
          r_hi    <= w_res[2*WIDTH-1:WIDTH];
          r_lo    <= w_res[WIDTH-1:0];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // ALU operands are decoded from registered state; zero whenever not owned.
  assign o_alu_a     = r_alu_sel ? r_p_hi : '0;
  assign o_alu_b     = (r_alu_sel && r_p_lo[0]) ? r_m : '0;
  assign o_alu_sel   = r_alu_sel;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;

  // Stall must react to the current E-stage instruction in the same cycle.
  assign o_stall_req = r_busy & (i_start | i_hilo_rd);

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed corner cases plus random
// operands, compared against a plain 64-bit arithmetic product.
module tb_mul_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        hilo_rd;
  logic [31:0] alu_sum;
  logic        alu_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        busy;
  logic        done;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests;
  int fails;

  mul_sequencer #(.WIDTH(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_sgn       (sgn),
    .i_srca      (srca),
    .i_srcb      (srcb),
    .i_hilo_rd   (hilo_rd),
    .i_alu_sum   (alu_sum),
    .o_alu_sel   (alu_sel),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .o_busy      (busy),
    .o_done      (done),
    .o_stall_req (stall_req),
    .o_hi        (hi),
    .o_lo        (lo)
  );

  // Execute-stage ALU doing an add when the sequencer owns it.
  assign alu_sum = alu_sel ? (alu_a + alu_b) : 32'h0BAD_F00D;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: sign- or zero-extend to 64 bits and multiply mod 2^64.
  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'h0, a};
    eb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one sampling edge.
  task automatic start_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    sgn   = s;
    srca  = a;
    srcb  = b;
    tick();
    start = 1'b0;
  endtask

  // Wait for done (bounded); n counts edges including the sampling edge.
  // Optionally pulses hilo_rd at step hilo_at and checks the stall.
  task automatic wait_done(input int hilo_at, output int lat, output int sel,
                           output logic busy_ok);
    int n;
    n       = 1;
    sel     = 0;
    busy_ok = 1'b1;
    while (!done && n < 60) begin
      if (alu_sel) sel++;
      if (!busy) busy_ok = 1'b0;
      if (n == hilo_at) begin
        hilo_rd = 1'b1;
        #1;
        check("stall_on_hilo_rd", 64'(stall_req), 64'd1);
        hilo_rd = 1'b0;
      end
      tick();
      n++;
    end
    lat = n;
  endtask

  task automatic run_check(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b);
    int          lat;
    int          sel;
    logic        bok;
    logic [63:0] exp;
    exp = ref_mul(s, a, b);
    start_mul(s, a, b);
    wait_done(0, lat, sel, bok);
    check({tag, "_latency"}, 64'(lat), 64'd34);
    check({tag, "_alu_sel_cycles"}, 64'(sel), 64'd32);
    check({tag, "_busy_held"}, 64'(bok), 64'd1);
    check({tag, "_alu_ab_idle"}, {alu_a, alu_b}, 64'd0);
    check({tag, "_hilo"}, {hi, lo}, exp);
  endtask

  initial begin
    int          lat;
    int          sel;
    logic        bok;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;

    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    start   = 1'b1;
    sgn     = 1'b0;
    srca    = 32'd0;
    srcb    = 32'd0;
    hilo_rd = 1'b1;

    // Reset state, with requests asserted that must not stall.
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_alu_sel", 64'(alu_sel), 64'd0);
    check("rst_alu_ab", {alu_a, alu_b}, 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst     = 1'b0;
    start   = 1'b0;
    hilo_rd = 1'b0;
    tick();

    // Directed products.
    run_check("u7x6", 1'b0, 32'd7, 32'd6);
    check("u7x6_lo_const", {hi, lo}, 64'h0000_0000_0000_002A);
    tick();
    check("done_one_cycle", 64'(done), 64'd0);
    check("hilo_held_idle", {hi, lo}, 64'h0000_0000_0000_002A);

    run_check("s_m3x5", 1'b1, 32'hFFFF_FFFD, 32'h0000_0005);
    check("s_m3x5_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_check("s_min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000);
    check("s_min_sq_const", {hi, lo}, 64'h4000_0000_0000_0000);
    run_check("u_max_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("u_max_sq_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_check("s_zero_neg", 1'b1, 32'd0, 32'hFFFF_FFF0);

    // Request while busy: stalled and ignored; then re-presented at done.
    start_mul(1'b0, 32'd2, 32'd3);
    tick();
    tick();
    tick();
    start = 1'b1;
    sgn   = 1'b0;
    srca  = 32'd9;
    srcb  = 32'd9;
    #1;
    check("stall_on_start_busy", 64'(stall_req), 64'd1);
    tick();
    start = 1'b0;
    wait_done(0, lat, sel, bok);
    check("ignored_start_latency", 64'(lat), 64'd30);
    check("ignored_start_result", {hi, lo}, 64'd6);
    hilo_rd = 1'b1;
    start   = 1'b1;
    #1;
    check("no_stall_done_cycle", 64'(stall_req), 64'd0);
    hilo_rd = 1'b0;
    start_mul(1'b0, 32'd9, 32'd9);
    wait_done(10, lat, sel, bok);
    check("b2b_latency", 64'(lat), 64'd34);
    check("b2b_result", {hi, lo}, 64'd81);

    // Reset mid-iteration, then recovery.
    tick();
    run_check("u4x4", 1'b0, 32'd4, 32'd4);
    start_mul(1'b1, 32'hFFFF_FFF9, 32'd5);
    for (int i = 0; i < 9; i++) tick();
    check("pre_rst_alu_sel", 64'(alu_sel), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_alu_sel", 64'(alu_sel), 64'd0);
    check("mid_rst_hilo", {hi, lo}, 64'd0);
    check("mid_rst_alu_ab", {alu_a, alu_b}, 64'd0);
    run_check("after_rst_2x2", 1'b0, 32'd2, 32'd2);

    // Random operands, both signednesses.
    for (int i = 0; i < 10; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (i == 0) a = 32'h8000_0000;
      if (i == 1) b = 32'hFFFF_FFFF;
      if (i == 2) b = 32'd1;
      run_check($sformatf("rand%0d", i), s, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle multiply controller for the execute stage. It sequences a 32-iteration shift-add multiply that borrows the shared execute-stage ALU as its adder, and owns the HI/LO result registers. It raises a stall request to the hazard unit while a new multiply or a HI/LO read would collide with an in-flight operation. All iteration state lives here; the ALU stays purely combinational.

## Interface
- WIDTH, 32, operand width; HI and LO are WIDTH each; iteration count = WIDTH.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  multiply request from the E-stage control (MultStartE).
- sgn  in  1  1 = signed (mult), 0 = unsigned (multu); sampled with start.
- srca, srcb  in  WIDTH  forwarded operands, sampled with start.
- hilo_rd  in  1  the E-stage instruction reads HI or LO (mfhi/mflo).
- alu_sum  in  WIDTH  ALU result (a+b) while alu_sel=1.
- alu_sel  out  1  1 = sequencer owns the ALU; the stage muxes alu_a/alu_b in and forces ALU op = add (010).
- alu_a, alu_b  out  WIDTH  ALU operands while alu_sel=1; 0 otherwise.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO are written.
- stall_req  out  1  to the hazard unit.
- hi, lo  out  WIDTH  result registers.

## Operation
- States: IDLE, ITER, FIX.
- IDLE, start=1:
  - Capture M=|srca|, P_lo=|srcb|, neg=sgn&(srca[W-1]^srcb[W-1]); P_hi=0, cnt=0 → ITER.
  - Magnitude is taken only when sgn=1.
  - -2^(W-1) has magnitude 2^(W-1), which fits unsigned.
- ITER, each cycle:
  - alu_a=P_hi, alu_b = P_lo[0] ? M : 0.
  - carry = (alu_sum < P_hi), unsigned compare done locally.
  - {P_hi,P_lo} <= {carry, alu_sum, P_lo[W-1:1]}; cnt++.
  - After cnt reaches W-1 → FIX.
- FIX:
  - {hi,lo} <= neg ? -{P_hi,P_lo} (2W-bit two's complement) : {P_hi,P_lo}.
  - done registered to 1 → IDLE.
- HI/LO change only in FIX; they hold their value across IDLE and ITER.
- alu_sel=1 only in ITER; alu_a/alu_b=0 outside ITER.
- busy=1 in ITER and FIX.
- stall_req = busy & (start | hilo_rd).
- start while busy: ignored (no re-capture); the hazard unit holds the instruction until it is re-presented in IDLE.
- A flush does not abort an in-flight multiply; there is no flush input.
- rst at any point, including mid-ITER: state=IDLE, cnt=0, P/M/neg=0, hi=lo=0, done=0, busy=0, alu_sel=0, alu_a=alu_b=0, stall_req=0.
- Zero operand: result 0 with neg ignored (negating 0 yields 0).

## Timing
- start sampled at edge T (IDLE).
- ITER occupies cycles T+1..T+W; FIX is cycle T+W+1.
- HI/LO update and done=1 at edge T+W+2, i.e. during cycle T+34 for W=32.
- done is high for exactly one cycle.
- busy is high from T+1 through T+W+1 inclusive.
- start in the same cycle done=1: accepted (state is IDLE), back-to-back with zero gap.
- hilo_rd in the done cycle: no stall; the reader sees the new HI/LO.
- Throughput: one multiply per W+2 cycles.

## Structure
- Shared package `mul_pkg`:
  - state enum {IDLE, ITER, FIX};
  - ALU_ADD = 3'b010;
  - default WIDTH.
- One sub-module, `mul_sign_fix`: combinational; operand magnitude (pre) and 2W-bit conditional negate (post). Instantiated for the pre and post steps.
- Counter is $clog2(WIDTH) bits.

## Test plan
- Unsigned 7×6, start at T: done at T+34; hi=0x00000000, lo=0x0000002A; alu_sel high for exactly 32 cycles.
- Signed -3×5 (0xFFFFFFFD, 0x00000005): hi=0xFFFFFFFF, lo=0xFFFFFFF1. Signed 0x80000000×0x80000000: hi=0x40000000, lo=0.
- Unsigned 0xFFFFFFFF×0xFFFFFFFF (carry path every iteration): hi=0xFFFFFFFE, lo=0x00000001.
- start with 2×3, then start with 9×9 at T+5: stall_req=1 at T+5, second request ignored; result 6. 9×9 re-presented at T+34: accepted, result 81 at T+68.
- hilo_rd=1 at T+10: stall_req=1; hilo_rd at T+34: stall_req=0, lo=result.
- Complete 4×4 (lo=16), then rst during iteration 10 of a new multiply: next cycle busy=0, hi=lo=0, alu_sel=0; a following 2×2 gives lo=4.
